// File: rtl/sync_queue_pkg.sv
// Shared types and helpers for the parametrised synchronous queue.
// Optional watermark output is enabled by SYNC_QUEUE_PARAM_WATERMARK_EN.
package sync_queue_pkg;

   localparam int unsigned DEFAULT_WIDTH = 128;
   localparam int unsigned DEFAULT_DEPTH = 64;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Count is carried at full 32 bits so the struct is independent of DEPTH.
   typedef struct packed {
      logic [31:0] count;
      logic        almost_full;
      logic        almost_empty;
   } queue_status_t;

   function automatic queue_status_t make_status(input logic [31:0]  count,
                                                 input int unsigned  af_level,
                                                 input int unsigned  ae_level);
      queue_status_t s;
      s.count        = count;
      s.almost_full  = (count >= af_level);
      s.almost_empty = (count <= ae_level);
      return s;
   endfunction

endpackage

// File: rtl/sync_queue_param_if.sv
// Handshake/status bundle between the queue and its producer/consumer.
// high_water exists only when SYNC_QUEUE_PARAM_WATERMARK_EN is defined.
interface sync_queue_param_if
   import sync_queue_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
);
   localparam int unsigned CW = count_width(DEPTH);

   logic             enq_ready;
   logic             enq_valid;
   logic [WIDTH-1:0] enq_bits;
   logic             deq_ready;
   logic             deq_valid;
   logic [WIDTH-1:0] deq_bits;
   logic             flush;
   logic [CW-1:0]    count;
   logic             almost_full;
   logic             almost_empty;
`ifdef SYNC_QUEUE_PARAM_WATERMARK_EN
   logic [CW-1:0]    high_water;
`endif

   modport master (
      input  enq_ready,
      output enq_valid,
      output enq_bits,
      output deq_ready,
      input  deq_valid,
      input  deq_bits,
      output flush,
      input  count,
      input  almost_full,
`ifdef SYNC_QUEUE_PARAM_WATERMARK_EN
      input  high_water,
`endif
      input  almost_empty
   );

   modport slave (
      output enq_ready,
      input  enq_valid,
      input  enq_bits,
      input  deq_ready,
      output deq_valid,
      output deq_bits,
      input  flush,
      output count,
      output almost_full,
`ifdef SYNC_QUEUE_PARAM_WATERMARK_EN
      output high_water,
`endif
      output almost_empty
   );

endinterface

// File: rtl/sync_queue_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sync_queue_ram #(
   parameter  int unsigned WIDTH = 128,
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sync_queue_param.sv
// Parametrised first-word-fall-through FIFO with flush and almost flags.
// Defining SYNC_QUEUE_PARAM_WATERMARK_EN adds the high_water register.
module sync_queue_param
   import sync_queue_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 4,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic              clock,
   input  logic              reset,
   sync_queue_param_if.slave io
);

   localparam int unsigned CW = count_width(DEPTH);
   localparam int unsigned AW = $clog2(DEPTH);

   queue_status_t    status_q;
   queue_status_t    status_d;
   logic [31:0]      count_d;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic             head_valid_q;
   logic             head_sel_q;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] ram_q;
   logic             enq_fire;
   logic             deq_fire;
   logic             bypass;
   logic             ram_wr;
   logic             ram_rd;

   assign io.enq_ready = (status_q.count < DEPTH) & ~io.flush;
   assign enq_fire     = io.enq_valid & io.enq_ready;
   assign deq_fire     = head_valid_q & io.deq_ready & ~io.flush;

   // The head always holds the oldest entry, so the RAM stores count-1 entries;
   // a write goes straight to the head whenever the head would otherwise be empty.
   assign bypass = enq_fire & ((status_q.count == 32'd0) |
                               ((status_q.count == 32'd1) & deq_fire));
   assign ram_wr = enq_fire & ~bypass;
   assign ram_rd = deq_fire & (status_q.count > 32'd1);

   always_comb begin
      count_d = status_q.count;
      if (io.flush) begin
         count_d = '0;
      end else if (enq_fire & ~deq_fire) begin
         count_d = status_q.count + 32'd1;
      end else if (deq_fire & ~enq_fire) begin
         count_d = status_q.count - 32'd1;
      end
      status_d = make_status(count_d, AF_LEVEL, AE_LEVEL);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         status_q     <= make_status('0, AF_LEVEL, AE_LEVEL);
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         head_valid_q <= 1'b0;
         head_sel_q   <= 1'b0;
      end else begin
         status_q     <= status_d;
         head_valid_q <= (count_d != 32'd0);
         if (io.flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_sel_q <= 1'b0;
         end else begin
            if (ram_wr) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ram_rd) begin
               rd_ptr_q   <= rd_ptr_q + 1'b1;
               head_sel_q <= 1'b1;
            end
            if (bypass) begin
               head_sel_q <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (bypass) begin
         head_q <= io.enq_bits;
      end
   end

   // The RAM's read register doubles as the head when the entry came from RAM.
   sync_queue_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clock   (clock),
      .wr_en   (ram_wr),
      .wr_addr (wr_ptr_q),
      .wr_data (io.enq_bits),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_q)
   );

   assign io.deq_valid    = head_valid_q;
   assign io.deq_bits     = head_sel_q ? ram_q : head_q;
   assign io.count        = status_q.count[CW-1:0];
   assign io.almost_full  = status_q.almost_full;
   assign io.almost_empty = status_q.almost_empty;

`ifdef SYNC_QUEUE_PARAM_WATERMARK_EN
   logic [CW-1:0] high_water_q;

   always_ff @(posedge clock) begin
      if (reset || io.flush) begin
         high_water_q <= '0;
      end else if (status_q.count[CW-1:0] > high_water_q) begin
         high_water_q <= status_q.count[CW-1:0];
      end
   end

   assign io.high_water = high_water_q;
`endif

endmodule
